// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-port SRAM arbiter: display reads take priority, render writes get a slot after a bounded read run
module sram_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int MAX_RD_RUN = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_gnt,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_gnt,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] io_SRAM_DQ,
   output logic              o_SRAM_WE_N
);
   localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

   state_t            state;
   logic [RUN_W-1:0]  run_cnt;
   logic              dq_oe;
   logic [DATA_W-1:0] dq_out;

   // Grants are decided combinationally in IDLE so the requester sees acceptance in the same cycle.
   always_comb begin
      o_rd_gnt = 1'b0;
      o_wr_gnt = 1'b0;
      if (!i_rst && state == IDLE) begin
         if (i_rd_req && !(i_wr_req && run_cnt == RUN_MAX))
            o_rd_gnt = 1'b1;
         else if (i_wr_req)
            o_wr_gnt = 1'b1;
      end
   end

   assign o_busy     = (state != IDLE);
   assign io_SRAM_DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         run_cnt     <= '0;
         o_rd_valid  <= 1'b0;
         o_rd_data   <= '0;
         o_SRAM_ADDR <= '0;
         o_SRAM_WE_N <= 1'b1;
         dq_oe       <= 1'b0;
         dq_out      <= '0;
      end else begin
         o_rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (o_rd_gnt) begin
                  state       <= RD_A;
                  o_SRAM_ADDR <= i_rd_addr;
                  if (!i_wr_req)
                     run_cnt <= '0;
                  else if (run_cnt != RUN_MAX)
                     run_cnt <= run_cnt + 1'b1;
               end else if (o_wr_gnt) begin
                  state       <= WR_SETUP;
                  o_SRAM_ADDR <= i_wr_addr;
                  dq_out      <= i_wr_data;
                  dq_oe       <= 1'b1;
                  run_cnt     <= '0;
               end else if (!i_wr_req) begin
                  run_cnt <= '0;
               end
            end
            RD_A: state <= RD_B;
            RD_B: begin
               state      <= IDLE;
               o_rd_valid <= 1'b1;
               o_rd_data  <= io_SRAM_DQ;
            end
            WR_SETUP: begin
               state       <= WR_PULSE;
               o_SRAM_WE_N <= 1'b0;
            end
            WR_PULSE: begin
               state       <= WR_HOLD;
               o_SRAM_WE_N <= 1'b1;
            end
            WR_HOLD: begin
               state <= IDLE;
               dq_oe <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized scoreboard bench for sram_arbiter with an SRAM device model
module tb_sram_arbiter;
   localparam int AW     = 20;
   localparam int DW     = 16;
   localparam int MAXRUN = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_req, wr_req;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] wr_data;
   logic          o_rd_gnt, o_rd_valid, o_wr_gnt, o_busy, o_SRAM_WE_N;
   logic [DW-1:0] o_rd_data;
   logic [AW-1:0] o_SRAM_ADDR;
   wire  [DW-1:0] sram_dq;
   logic          tb_drv = 1'b0;
   logic [DW-1:0] tb_dq  = '0;

   assign sram_dq = tb_drv ? tb_dq : {DW{1'bz}};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD_RUN(MAXRUN)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(o_rd_gnt),
      .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(o_wr_gnt),
      .o_busy(o_busy), .o_SRAM_ADDR(o_SRAM_ADDR), .io_SRAM_DQ(sram_dq), .o_SRAM_WE_N(o_SRAM_WE_N)
   );

   typedef struct { int due; logic [DW-1:0] data; } rd_exp_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;

   rd_exp_t       rd_q[$];
   wr_exp_t       wr_q[$];
   logic [DW-1:0] model_mem [logic [AW-1:0]];
   logic [DW-1:0] dev_mem   [logic [AW-1:0]];

   function automatic logic [DW-1:0] fill_word(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hA5A5;
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return model_mem.exists(a) ? model_mem[a] : fill_word(a);
   endfunction

   function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : fill_word(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: an access occupies the bus for a fixed number of cycles after its grant.
   int            cyc = 0, acc = 0, step = 0, run = 0, drv_cnt = 0;
   bit            started = 0;
   logic [AW-1:0] last_addr = '0;
   logic [DW-1:0] cur_wdata = '0, exp_rdata = '0;

   always @(negedge clk) begin
      bit      idle, exp_rd, exp_wr;
      rd_exp_t re;
      wr_exp_t we;
      idle   = (acc == 0);
      exp_rd = !rst && idle && rd_req && !(wr_req && run == MAXRUN);
      exp_wr = !rst && idle && wr_req && !exp_rd;
      if (started) begin
         check("rd_gnt", o_rd_gnt, exp_rd);
         check("wr_gnt", o_wr_gnt, exp_wr);
         check("busy", o_busy, !idle);
         check("we_n", o_SRAM_WE_N, !(acc == 2 && step == 2));
         check("sram_addr", o_SRAM_ADDR, last_addr);
         if (acc == 2) check("wr_dq", sram_dq, cur_wdata);
         if (o_rd_valid) begin
            if (rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_valid: unexpected pulse with data 0x%0h, required none", o_rd_data);
            end else begin
               re = rd_q.pop_front();
               check("rd_valid_cycle", cyc, re.due);
               check("rd_data", o_rd_data, re.data);
               exp_rdata = re.data;
            end
         end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL rd_valid_missing: no pulse at cycle %0d, required one", rd_q[0].due);
            rd_q.delete(0);
         end
         check("rd_data_hold", o_rd_data, exp_rdata);
         if (!o_SRAM_WE_N) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL we_pulse: unexpected write to 0x%0h, required none", o_SRAM_ADDR);
            end else begin
               we = wr_q.pop_front();
               check("wr_pulse_addr", o_SRAM_ADDR, we.addr);
               check("wr_pulse_data", sram_dq, we.data);
            end
         end
      end

      if (!o_SRAM_WE_N) dev_mem[o_SRAM_ADDR] = sram_dq;

      if (rst) begin
         acc = 0; step = 0; run = 0;
         last_addr = '0; exp_rdata = '0;
         rd_q.delete(); wr_q.delete();
         drv_cnt = 0; tb_drv = 1'b0;
         started = 1;
      end else begin
         if (acc != 0) begin
            step++;
            if ((acc == 1 && step == 3) || (acc == 2 && step == 4)) begin
               acc = 0; step = 0;
            end
         end
         if (exp_rd) begin
            acc = 1; step = 1; last_addr = rd_addr;
            rd_q.push_back('{cyc + 3, model_read(rd_addr)});
            run = wr_req ? ((run < MAXRUN) ? run + 1 : MAXRUN) : 0;
         end else if (exp_wr) begin
            acc = 2; step = 1; last_addr = wr_addr; cur_wdata = wr_data;
            model_mem[wr_addr] = wr_data;
            wr_q.push_back('{wr_addr, wr_data});
            run = 0;
         end else if (idle && !wr_req) begin
            run = 0;
         end
         // The SRAM device drives DQ from the read grant until just after the data is sampled.
         if (drv_cnt > 0) drv_cnt--;
         else tb_drv = 1'b0;
         if (exp_rd) begin
            tb_drv = 1'b1; drv_cnt = 2;
         end
         if (tb_drv) tb_dq = dev_read(o_SRAM_ADDR);
      end
      cyc++;
   end

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_gnt(input bit is_wr, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = is_wr ? o_wr_gnt : o_rd_gnt;
      end
      @(posedge clk); #1;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_gnt_timeout: no grant within 200 cycles, required one", is_wr ? "wr" : "rd");
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      bit ok;
      rd_addr = a; rd_req = 1'b1;
      wait_gnt(1'b0, ok);
      rd_req = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit ok;
      wr_addr = a; wr_data = d; wr_req = 1'b1;
      wait_gnt(1'b1, ok);
      wr_req = 1'b0;
   endtask

   task automatic rd_agent(input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         idle_cycles($urandom_range(0, 3));
         rd_addr = 20'h00100 + 20'($urandom_range(0, 15));
         rd_req  = 1'b1;
         if ($urandom_range(0, 7) == 0) begin
            idle_cycles($urandom_range(1, 3));
            rd_req = 1'b0;
         end else begin
            wait_gnt(1'b0, ok);
            rd_req = 1'b0;
         end
      end
   endtask

   task automatic wr_agent(input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         idle_cycles($urandom_range(0, 6));
         wr_addr = 20'h00100 + 20'($urandom_range(0, 15));
         wr_data = 16'($urandom);
         wr_req  = 1'b1;
         if ($urandom_range(0, 7) == 0) begin
            idle_cycles($urandom_range(1, 3));
            wr_req = 1'b0;
         end else begin
            wait_gnt(1'b1, ok);
            wr_req = 1'b0;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500000, required finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit ok;
      int n, cycles, rd_t, wr_t, nrd;
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      dev_mem[20'h00123]   = 16'hBEEF;
      model_mem[20'h00123] = 16'hBEEF;
      do_read(20'h00123);
      idle_cycles(4);
      do_write(20'h0ABCD, 16'h1234);
      idle_cycles(5);
      do_read(20'h0ABCD);
      idle_cycles(4);

      // Both requesters held: eight reads then one write, twice over.
      rd_addr = 20'h00200; wr_addr = 20'h00201; wr_data = 16'h5A5A;
      idle_cycles(2);
      rd_req = 1'b1; wr_req = 1'b1;
      n = 0; cycles = 0;
      while (n < 18 && cycles < 200) begin
         @(negedge clk);
         cycles++;
         if (o_rd_gnt || o_wr_gnt) begin
            check("starve_seq", o_wr_gnt, (n % 9) == 8);
            n++;
         end
      end
      check("starve_count", n, 18);
      @(posedge clk); #1;
      rd_req = 1'b0; wr_req = 1'b0;
      idle_cycles(6);

      rd_addr = 20'h00300; wr_addr = 20'h00301; wr_data = 16'hC0DE;
      rd_req = 1'b1; wr_req = 1'b1;
      rd_t = -1; wr_t = -1; cycles = 0;
      while ((rd_t < 0 || wr_t < 0) && cycles < 30) begin
         @(negedge clk);
         if (o_rd_gnt && rd_t < 0) rd_t = cycles;
         if (o_wr_gnt && wr_t < 0) wr_t = cycles;
         cycles++;
         @(posedge clk); #1;
         if (rd_t >= 0) rd_req = 1'b0;
         if (wr_t >= 0) wr_req = 1'b0;
      end
      rd_req = 1'b0; wr_req = 1'b0;
      check("contend_rd_first", rd_t, 0);
      check("contend_wr_next_idle", wr_t, 3);
      idle_cycles(5);

      // Reset while the write strobe is low.
      wr_addr = 20'h00400; wr_data = 16'h0F0F; wr_req = 1'b1;
      wait_gnt(1'b1, ok);
      wr_req = 1'b0;
      @(posedge clk); #1;
      check("rst_pre_we_n", o_SRAM_WE_N, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_we_n", o_SRAM_WE_N, 1'b1);
      check("rst_busy", o_busy, 1'b0);
      check("rst_rd_valid", o_rd_valid, 1'b0);
      check("rst_gnt", o_rd_gnt | o_wr_gnt, 1'b0);
      rst = 1'b0;
      idle_cycles(3);

      wr_addr = 20'h00500; wr_data = 16'h7777; wr_req = 1'b1;
      wait_gnt(1'b1, ok);
      wr_req = 1'b0;
      rd_addr = 20'h00501; rd_req = 1'b1;
      @(posedge clk); #1;
      rd_req = 1'b0;
      nrd = 0;
      repeat (8) begin
         @(negedge clk);
         if (o_rd_gnt) nrd++;
      end
      check("withdrawn_no_gnt", nrd, 0);
      @(posedge clk); #1;

      fork
         rd_agent(150);
         wr_agent(150);
      join
      idle_cycles(10);
      do_read(20'h0ABCD);
      idle_cycles(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
